fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameters: none; the boot vector (32'h00000000) and interrupt vector (32'hFF00000A) SHALL come from ecap5_dproc_pkg constants BOOT_ADDRESS and INTERRUPT_ADDRESS.
REQ-002 clk_i  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 irq_i  in  1  single-cycle interrupt redirect pulse.
REQ-005 branch_i  in  1  redirect request from execute.
REQ-006 branch_target_i  in  32  redirect address, used verbatim with no realignment.
REQ-007 output_ready_i  in  1  decode ready to accept.
REQ-008 output_valid_o  out  1  instr_o/pc_o valid.
REQ-009 instr_o  out  32  fetched instruction word.
REQ-010 pc_o  out  32  address of instr_o.
REQ-011 wb_adr_o  out  32  memory address.
REQ-012 wb_cyc_o  out  1  bus cycle active.
REQ-013 wb_stb_o  out  1  request strobe.
REQ-014 wb_dat_i  in  32  read data.
REQ-015 wb_ack_i  in  1  read data valid.
REQ-016 wb_stall_i  in  1  slave cannot accept the strobe.

Function
REQ-017 The FSM SHALL have three states: REQUEST, WAIT_ACK and HOLD.
REQ-018 REQUEST: cyc=1, stb=1, adr=pc; stay while stall=1 with adr and stb stable; on stall=0 go to WAIT_ACK.
REQ-019 WAIT_ACK: stb=0, cyc=1; on ack=1 go to HOLD, capture wb_dat_i into instr_o and pc into pc_o, and set pc<=pc+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0).
REQ-020 HOLD: output_valid_o=1, cyc=0, stb=0; on output_ready_i=1 drop valid on the next cycle and go to REQUEST.
REQ-021 Minimum latency SHALL be: strobe issued the cycle after entering REQUEST; valid asserted the cycle after ack; throughput at most one instruction per 3 cycles.
REQ-022 While output_valid_o=1 and output_ready_i=0, instr_o and pc_o SHALL stay stable.
REQ-023 Redirect: irq_i=1 SHALL set pc<=INTERRUPT_ADDRESS; otherwise branch_i=1 SHALL set pc<=branch_target_i; irq_i has priority when both are high.
REQ-024 Redirect in REQUEST with stall=1: the next cycle's adr SHALL show the new pc (abandoning the strobe is allowed only while stalled).
REQ-025 Redirect in REQUEST with stall=0: the request SHALL be marked discard.
REQ-026 Redirect in WAIT_ACK, including the same cycle as ack: the in-flight response SHALL be discarded (no valid, pc not incremented), then go to REQUEST.
REQ-027 Redirect in HOLD: output_valid_o SHALL drop on the next cycle regardless of ready, then go to REQUEST.
REQ-028 A discarded request's ack SHALL be consumed silently before a new strobe is issued; only one transaction SHALL be outstanding at a time.

Reset
REQ-029 While rst_i=1 and on its release: pc=BOOT_ADDRESS, state=REQUEST, discard flag=0, output_valid_o=0, instr_o=0, pc_o=0, wb_cyc_o=0, wb_stb_o=0, wb_adr_o=0.
REQ-030 The first strobe SHALL assert on the first clock edge after rst_i falls.
REQ-031 Reset mid-transaction SHALL abandon it; a late ack after reset, before the first strobe, SHALL be ignored.

Structure
REQ-032 The fetch FSM state typedef SHALL be added to ecap5_dproc_pkg.
REQ-033 The pc increment (32'd4) SHALL be a package localparam.
REQ-034 No sub-module: FSM, pc register and output buffer SHALL be in one module.

Verification
REQ-035 Reset, zero-wait memory returning 32'h00000013 at 0 -> adr=0 strobe, then valid with pc_o=0, instr_o=32'h00000013, next adr=4.
REQ-036 Stall held 3 cycles at adr=8 -> adr=8 and stb=1 constant for 3 cycles, exactly one transaction.
REQ-037 output_ready_i=0 for 5 cycles in HOLD -> instr_o/pc_o unchanged, cyc=0 throughout.
REQ-038 branch_i=1, target=32'h00000100, on the ack cycle -> data discarded, no valid, next adr=32'h00000100.
REQ-039 irq_i and branch_i together, target 32'h200 -> next adr=32'hFF00000A.
REQ-040 rst_i asserted during WAIT_ACK -> all outputs 0 immediately, then first adr=0 after release.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// Shared constants and types for the ecap5 data-processor pipeline.
// Holds the fetch-stage vectors, pc step and FSM state encoding.
package ecap5_dproc_pkg;

   localparam logic [31:0] BOOT_ADDRESS      = 32'h00000000;
   localparam logic [31:0] INTERRUPT_ADDRESS = 32'hFF00000A;
   localparam logic [31:0] PC_INCREMENT      = 32'd4;

   typedef enum logic [1:0] {
      FETCH_REQUEST  = 2'd0,
      FETCH_WAIT_ACK = 2'd1,
      FETCH_HOLD     = 2'd2
   } fetch_state_t;

   // Interrupts win over branches when both redirect in the same cycle.
   function automatic logic [31:0] redirect_target(input logic irq,
                                                   input logic [31:0] branch_target);
      logic [31:0] target;
      if (irq) begin
         target = INTERRUPT_ADDRESS;
      end else begin
         target = branch_target;
      end
      return target;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Pipelined Wishbone read port used by the fetch stage.
// The master modport is the fetch side, the slave modport is memory.
interface fetch_if;
   import ecap5_dproc_pkg::*;

   logic [31:0] wb_adr_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_stall_i;

   modport master (
      output wb_adr_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_stall_i
   );

   modport slave (
      input  wb_adr_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_stall_i
   );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: one outstanding Wishbone read at a time, a one-entry
// output buffer towards decode, and branch/interrupt redirection.
module fetch
   import ecap5_dproc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        irq_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        output_ready_i,
   output logic        output_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   fetch_if.master     wb
);

   fetch_state_t state_r, state_s;
   logic [31:0]  pc_r, pc_s;
   logic         discard_r, discard_s;
   logic         valid_r, valid_s;
   logic [31:0]  instr_r, instr_s;
   logic [31:0]  pc_out_r, pc_out_s;
   logic         cyc_r, cyc_s;
   logic         stb_r, stb_s;
   logic [31:0]  adr_r, adr_s;
   logic         redirect_s;
   logic [31:0]  target_s;

   // Next-state and next-output computation; every output is registered.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      discard_s  = discard_r;
      valid_s    = valid_r;
      instr_s    = instr_r;
      pc_out_s   = pc_out_r;
      cyc_s      = cyc_r;
      stb_s      = stb_r;
      adr_s      = adr_r;
      redirect_s = irq_i | branch_i;
      target_s   = redirect_target(irq_i, branch_target_i);

      case (state_r)
         FETCH_REQUEST: begin
            if (redirect_s) begin
               pc_s = target_s;
            end else begin
               pc_s = pc_r;
            end
            // A strobe already on the bus and not stalled has been taken;
            // any redirect now has to throw its response away.
            if (stb_r && !wb.wb_stall_i) begin
               state_s   = FETCH_WAIT_ACK;
               stb_s     = 1'b0;
               cyc_s     = 1'b1;
               discard_s = redirect_s;
            end else begin
               stb_s = 1'b1;
               cyc_s = 1'b1;
               adr_s = pc_s;
            end
         end
         FETCH_WAIT_ACK: begin
            stb_s = 1'b0;
            cyc_s = 1'b1;
            if (wb.wb_ack_i) begin
               cyc_s     = 1'b0;
               discard_s = 1'b0;
               if (discard_r || redirect_s) begin
                  state_s = FETCH_REQUEST;
                  pc_s    = redirect_s ? target_s : pc_r;
               end else begin
                  state_s  = FETCH_HOLD;
                  valid_s  = 1'b1;
                  instr_s  = wb.wb_dat_i;
                  pc_out_s = pc_r;
                  pc_s     = pc_r + PC_INCREMENT;
               end
            end else if (redirect_s) begin
               pc_s      = target_s;
               discard_s = 1'b1;
            end else begin
               discard_s = discard_r;
            end
         end
         FETCH_HOLD: begin
            cyc_s = 1'b0;
            stb_s = 1'b0;
            if (redirect_s) begin
               pc_s    = target_s;
               valid_s = 1'b0;
               state_s = FETCH_REQUEST;
            end else if (output_ready_i) begin
               valid_s = 1'b0;
               state_s = FETCH_REQUEST;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s   = FETCH_REQUEST;
            discard_s = 1'b0;
            valid_s   = 1'b0;
            cyc_s     = 1'b0;
            stb_s     = 1'b0;
         end
      endcase
   end

   // State, pc and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= FETCH_REQUEST;
         pc_r      <= BOOT_ADDRESS;
         discard_r <= 1'b0;
         valid_r   <= 1'b0;
         instr_r   <= 32'h00000000;
         pc_out_r  <= 32'h00000000;
         cyc_r     <= 1'b0;
         stb_r     <= 1'b0;
         adr_r     <= 32'h00000000;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         discard_r <= discard_s;
         valid_r   <= valid_s;
         instr_r   <= instr_s;
         pc_out_r  <= pc_out_s;
         cyc_r     <= cyc_s;
         stb_r     <= stb_s;
         adr_r     <= adr_s;
      end
   end

   assign output_valid_o = valid_r;
   assign instr_o        = instr_r;
   assign pc_o           = pc_out_r;
   assign wb.wb_adr_o    = adr_r;
   assign wb.wb_cyc_o    = cyc_r;
   assign wb.wb_stb_o    = stb_r;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a zero-wait memory model, a scoreboard of
// expected decode transfers, and one task per scenario.
module tb_fetch;
   import ecap5_dproc_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        ready = 1'b0;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc_out;

   logic        mem_ack = 1'b0;
   logic [31:0] mem_dat = 32'h0;
   logic        late_ack = 1'b0;
   logic        ack_en = 1'b1;
   logic        pending = 1'b0;
   logic [31:0] pend_adr = 32'h0;
   int          acc_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   exp_t        mon_e;

   fetch_if bus ();

   assign bus.wb_ack_i = mem_ack | late_ack;
   assign bus.wb_dat_i = late_ack ? 32'hDEADBEEF : mem_dat;

   fetch dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .irq_i           (irq),
      .branch_i        (branch),
      .branch_target_i (branch_target),
      .output_ready_i  (ready),
      .output_valid_o  (valid),
      .instr_o         (instr),
      .pc_o            (pc_out),
      .wb              (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h00000013;
   endfunction

   // Memory: accepts an unstalled strobe, acks it on the following cycle.
   always @(negedge clk) begin
      pending = bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i;
      if (pending) begin
         pend_adr = bus.wb_adr_o;
         acc_cnt++;
      end
   end

   always @(posedge clk) begin
      #1;
      mem_ack = pending && ack_en;
      mem_dat = mem_word(pend_adr);
   end

   // Scoreboard: each decode handshake pops and compares one expectation.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: pc_o=%h instr_o=%h, no transfer expected", pc_out, instr);
         end else begin
            mon_e = sb.pop_front();
            if (pc_out !== mon_e.pc || instr !== mon_e.instr) begin
               n_fail++;
               $display("FAIL sb_transfer: pc_o=%h instr_o=%h, expected pc=%h instr=%h",
                        pc_out, instr, mon_e.pc, mon_e.instr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_out();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic wait_strobe(input string name);
      int n = 0;
      while (bus.wb_stb_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      n_checks++;
      if (bus.wb_stb_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_strobe_timeout: stb=%b, required 1 within 20 cycles", name, bus.wb_stb_o);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      n_checks++;
      if (valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_valid_timeout: valid=%b, required 1 within 30 cycles", name, valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({valid, bus.wb_cyc_o, bus.wb_stb_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid/cyc/stb=%b, required 000", {valid, bus.wb_cyc_o, bus.wb_stb_o});
      end
      n_checks++;
      if (bus.wb_adr_o !== 32'h0 || instr !== 32'h0 || pc_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: adr=%h instr=%h pc_o=%h, required all 0", bus.wb_adr_o, instr, pc_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      sb.push_back('{pc: 32'h0, instr: 32'h00000013});
      tick();
      n_checks++;
      if (bus.wb_stb_o !== 1'b1 || bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL first_strobe: stb=%b cyc=%b adr=%h, required 1 1 00000000",
                  bus.wb_stb_o, bus.wb_cyc_o, bus.wb_adr_o);
      end
      tick();
      n_checks++;
      if (bus.wb_stb_o !== 1'b0 || bus.wb_cyc_o !== 1'b1 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_ack: stb=%b cyc=%b valid=%b, required 0 1 0", bus.wb_stb_o, bus.wb_cyc_o, valid);
      end
      tick();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h00000013 || bus.wb_cyc_o !== 1'b0) begin
         n_fail++;
         $display("FAIL first_valid: valid=%b pc_o=%h instr=%h cyc=%b, required 1 00000000 00000013 0",
                  valid, pc_out, instr, bus.wb_cyc_o);
      end
      release_out();
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_drop: valid=%b, required 0", valid);
      end
      tick();
      n_checks++;
      if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 32'h4) begin
         n_fail++;
         $display("FAIL next_adr: stb=%b adr=%h, required 1 00000004", bus.wb_stb_o, bus.wb_adr_o);
      end
      sb.push_back('{pc: 32'h4, instr: mem_word(32'h4)});
      wait_valid("basic");
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'b1 || pc_out !== 32'h4 || instr !== mem_word(32'h4) || bus.wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: valid=%b pc_o=%h instr=%h cyc=%b, required 1 00000004 %h 0",
                     i, valid, pc_out, instr, bus.wb_cyc_o, mem_word(32'h4));
         end
      end
      release_out();
   endtask

   task automatic test_stall();
      int base;
      base = acc_cnt;
      bus.wb_stall_i = 1'b1;
      wait_strobe("stall");
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: stb=%b adr=%h, required 1 00000008", i, bus.wb_stb_o, bus.wb_adr_o);
         end
      end
      bus.wb_stall_i = 1'b0;
      sb.push_back('{pc: 32'h8, instr: mem_word(32'h8)});
      wait_valid("stall");
      n_checks++;
      if (acc_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL stall_txn_count: transactions=%0d, required 1", acc_cnt - base);
      end
      release_out();
   endtask

   task automatic test_branch_on_ack();
      wait_strobe("branch_ack");
      tick();
      branch = 1'b1;
      branch_target = 32'h00000100;
      tick();
      branch = 1'b0;
      n_checks++;
      if (valid !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_ack_discard: valid=%b stb=%b, required 0 0", valid, bus.wb_stb_o);
      end
      wait_strobe("branch_ack_redirect");
      n_checks++;
      if (bus.wb_adr_o !== 32'h00000100 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_ack_adr: adr=%h valid=%b, required 00000100 0", bus.wb_adr_o, valid);
      end
      wait_valid("branch_ack");
      n_checks++;
      if (pc_out !== 32'h00000100 || instr !== mem_word(32'h100)) begin
         n_fail++;
         $display("FAIL branch_target_fetch: pc_o=%h instr=%h, required 00000100 %h",
                  pc_out, instr, mem_word(32'h100));
      end
   endtask

   task automatic test_irq_priority();
      irq = 1'b1;
      branch = 1'b1;
      branch_target = 32'h00000200;
      tick();
      irq = 1'b0;
      branch = 1'b0;
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_redirect_drop: valid=%b, required 0", valid);
      end
      wait_strobe("irq");
      n_checks++;
      if (bus.wb_adr_o !== 32'hFF00000A) begin
         n_fail++;
         $display("FAIL irq_priority_adr: adr=%h, required ff00000a", bus.wb_adr_o);
      end
      wait_valid("irq");
      n_checks++;
      if (pc_out !== 32'hFF00000A || instr !== mem_word(32'hFF00000A)) begin
         n_fail++;
         $display("FAIL irq_fetch: pc_o=%h instr=%h, required ff00000a %h",
                  pc_out, instr, mem_word(32'hFF00000A));
      end
   endtask

   task automatic test_wrap();
      branch = 1'b1;
      branch_target = 32'hFFFFFFFC;
      tick();
      branch = 1'b0;
      wait_strobe("wrap");
      n_checks++;
      if (bus.wb_adr_o !== 32'hFFFFFFFC) begin
         n_fail++;
         $display("FAIL wrap_adr: adr=%h, required fffffffc", bus.wb_adr_o);
      end
      sb.push_back('{pc: 32'hFFFFFFFC, instr: mem_word(32'hFFFFFFFC)});
      wait_valid("wrap");
      release_out();
   endtask

   task automatic test_redirect_stalled();
      bus.wb_stall_i = 1'b1;
      wait_strobe("redir_stall");
      n_checks++;
      if (bus.wb_adr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL pc_wrap: adr=%h, required 00000000", bus.wb_adr_o);
      end
      branch = 1'b1;
      branch_target = 32'h00000300;
      tick();
      branch = 1'b0;
      n_checks++;
      if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 32'h00000300) begin
         n_fail++;
         $display("FAIL stall_redirect_adr: stb=%b adr=%h, required 1 00000300", bus.wb_stb_o, bus.wb_adr_o);
      end
      bus.wb_stall_i = 1'b0;
      sb.push_back('{pc: 32'h300, instr: mem_word(32'h300)});
      wait_valid("redir_stall");
      release_out();
   endtask

   task automatic test_redirect_accepted();
      wait_strobe("redir_accept");
      branch = 1'b1;
      branch_target = 32'h00000400;
      tick();
      branch = 1'b0;
      tick();
      n_checks++;
      if (valid !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_discard: valid=%b cyc=%b, required 0 0", valid, bus.wb_cyc_o);
      end
      wait_strobe("redir_accept_next");
      n_checks++;
      if (bus.wb_adr_o !== 32'h00000400) begin
         n_fail++;
         $display("FAIL accept_redirect_adr: adr=%h, required 00000400", bus.wb_adr_o);
      end
      sb.push_back('{pc: 32'h400, instr: mem_word(32'h400)});
      wait_valid("redir_accept");
      release_out();
   endtask

   task automatic test_reset_in_wait();
      wait_strobe("rst_wait");
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({valid, bus.wb_cyc_o, bus.wb_stb_o} !== 3'b000 || bus.wb_adr_o !== 32'h0 ||
          instr !== 32'h0 || pc_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_txn: valid/cyc/stb=%b adr=%h instr=%h pc_o=%h, required all 0",
                  {valid, bus.wb_cyc_o, bus.wb_stb_o}, bus.wb_adr_o, instr, pc_out);
      end
      late_ack = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 32'h0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_restart: stb=%b adr=%h valid=%b, required 1 00000000 0",
                  bus.wb_stb_o, bus.wb_adr_o, valid);
      end
      late_ack = 1'b0;
      sb.push_back('{pc: 32'h0, instr: 32'h00000013});
      wait_valid("rst_wait");
      release_out();
      tick();
   endtask

   initial begin
      bus.wb_stall_i = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_stall();
      test_branch_on_ack();
      test_irq_priority();
      test_wrap();
      test_redirect_stalled();
      test_redirect_accepted();
      test_reset_in_wait();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expected transfers never seen, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
